regfile_writeback_unit: RTL
===========================

# regfile_writeback_unit

Write-side front end of the register file: collects results from the ALU and from the load/store unit through valid/ready handshakes and buffers them in a small FIFO. It then drives the register file's single write port (reg_write, wr_register, wr_data) with at most one write per cycle. It also exports a pending-write mask so that decode/hazard logic can stall reads of registers whose new value is still queued.

## Interface
- DATA_WIDTH, 32, width of register data
- ADDR_WIDTH, 5, register index width (32 registers, x0 hard-wired zero)
- FIFO_DEPTH, 4, buffered writes; power of two, ≥2

- clock_i  in  1  clock; all state updates on rising edge
- reset_i  in  1  synchronous, active-low reset (sampled on rising edge of clock_i)
- alu_valid_i  in  1  ALU result present
- alu_ready_o  out  1  ALU result accepted when alu_valid_i & alu_ready_o at edge
- alu_rd_i  in  ADDR_WIDTH  ALU destination register
- alu_data_i  in  DATA_WIDTH  ALU result
- mem_valid_i  in  1  load result present
- mem_ready_o  out  1  load result accepted when mem_valid_i & mem_ready_o at edge
- mem_rd_i  in  ADDR_WIDTH  load destination register
- mem_data_i  in  DATA_WIDTH  load data
- wr_stall_i  in  1  write port borrowed by another writer this cycle; no pop
- reg_write_o  out  1  write enable to register file
- wr_register_o  out  ADDR_WIDTH  write index to register file
- wr_data_o  out  DATA_WIDTH  write data to register file
- pending_o  out  2^ADDR_WIDTH  bit r set when any queued entry targets r
- count_o  out  clog2(FIFO_DEPTH)+1  current occupancy

## Operation
- FIFO of {rd, data}; up to two pushes and one pop per cycle.
- Ready is computed from registered count and mem_valid_i only, never from wr_stall_i:
  - mem_ready_o = count < FIFO_DEPTH
  - alu_ready_o = count ≤ FIFO_DEPTH-2, or count == FIFO_DEPTH-1 with mem_valid_i low
  - Load has priority for the last slot; ALU may starve while loads stream (by design).
- Simultaneous accept: the mem entry is enqueued first, then the alu entry (the load is the older instruction).
- rd == 0: the handshake completes normally, but nothing is enqueued and no slot is consumed.
- Pop: when count > 0 and wr_stall_i is low, the head is written and removed at the edge.
- Outputs:
  - reg_write_o = (count > 0) & ~wr_stall_i & reset_i.
  - wr_register_o and wr_data_o show the head entry when count > 0, and 0 otherwise.
- Occupancy update: next count = count + pushes − pop. Pointers wrap modulo FIFO_DEPTH.
- pending_o is the OR of the one-hot decode over valid entries; bit 0 is always 0.
- Full + pop: ready is still low this cycle (based on registered count), so no push occurs.

## Timing
- Reset (reset_i low at edge): count, pointers and pending cleared.
  - While reset_i is low, alu_ready_o, mem_ready_o and reg_write_o are forced 0.
  - After reset all outputs are 0.
- Latency: a result accepted at edge N appears on the write port in cycle N+1 and is written into the register file at edge N+1, if not stalled.
- Second entry of a simultaneous pair is written at edge N+2.
- Each cycle of wr_stall_i high delays the head by one cycle; the head is held stable.
- pending bit for r rises the cycle after accept. It falls the cycle after the last entry for r pops.
- Reset mid-operation discards all queued writes; none reach the register file.

## Structure
- Shared package/defines: DATA_WIDTH, ADDR_WIDTH, register count, x0 index.
- Sub-module wb_fifo: dual-push, single-pop synchronous FIFO with entry-valid vector exposed for the pending mask.
- Top: handshake/ready logic, x0 filter, push ordering, pending decode.

## Test plan
- Reset: hold reset_i low 2 cycles with both valids high.
  - Required: readys 0, reg_write_o 0, count_o 0, pending_o 0.
- Single ALU write: alu rd=1, data=0x55555555 accepted at edge N.
  - Cycle N+1: reg_write_o=1, wr_register_o=1, wr_data_o=0x55555555.
  - pending_o[1] set in cycle N+1, clear in cycle N+2.
- Simultaneous same rd: mem rd=2 data=0xAAAAAAAA and alu rd=2 data=0x12345678 in the same cycle.
  - Required: 0xAAAAAAAA written first, then 0x12345678; register 2 ends at 0x12345678.
- x0 filter: alu rd=0 data=0xFFFFFFFF.
  - Required: alu_ready_o=1, count_o stays 0, reg_write_o never rises.
- Full/stall: hold wr_stall_i=1 and push until count_o=4.
  - Required: mem_ready_o=0 and alu_ready_o=0 while full.
  - Release the stall: writes drain one per cycle in FIFO order.
  - With count=3 and both valid: only mem accepted.
- Reset mid-drain: 3 entries queued, reset_i low for one edge.
  - Required: no further reg_write_o, count_o=0, pending_o=0.

Source files
------------

// File: rtl/regfile_writeback_unit_pkg.sv
// Shared constants for the register-file write-back front end.
package regfile_writeback_unit_pkg;

    // Width of one register value.
    localparam int WB_DATA_WIDTH = 32;
    // Register index width (32 architectural registers).
    localparam int WB_ADDR_WIDTH = 5;
    // Number of buffered writes; must be a power of two and at least 2.
    localparam int WB_FIFO_DEPTH = 4;
    // Number of architectural registers addressed by the write port.
    localparam int WB_NUM_REGS   = 1 << WB_ADDR_WIDTH;
    // Index of the hard-wired zero register; writes to it are dropped.
    localparam int WB_X0_IDX     = 0;

endpackage : regfile_writeback_unit_pkg

// File: rtl/regfile_writeback_unit_if.sv
// Bundle of the ALU/load handshakes, the register-file write port and the
// status outputs of the write-back unit.
interface regfile_writeback_unit_if #(
    parameter int DATA_WIDTH = regfile_writeback_unit_pkg::WB_DATA_WIDTH,
    parameter int ADDR_WIDTH = regfile_writeback_unit_pkg::WB_ADDR_WIDTH,
    parameter int FIFO_DEPTH = regfile_writeback_unit_pkg::WB_FIFO_DEPTH
);
    localparam int CNT_WIDTH = $clog2(FIFO_DEPTH) + 1;
    localparam int NUM_REGS  = 1 << ADDR_WIDTH;

    // ALU result channel
    logic                   alu_valid_i;
    logic                   alu_ready_o;
    logic [ADDR_WIDTH-1:0]  alu_rd_i;
    logic [DATA_WIDTH-1:0]  alu_data_i;

    // Load result channel
    logic                   mem_valid_i;
    logic                   mem_ready_o;
    logic [ADDR_WIDTH-1:0]  mem_rd_i;
    logic [DATA_WIDTH-1:0]  mem_data_i;

    // Register-file write port
    logic                   wr_stall_i;
    logic                   reg_write_o;
    logic [ADDR_WIDTH-1:0]  wr_register_o;
    logic [DATA_WIDTH-1:0]  wr_data_o;

    // Status towards decode/hazard logic
    logic [NUM_REGS-1:0]    pending_o;
    logic [CNT_WIDTH-1:0]   count_o;

    // Producer side: pipeline stages and the register file environment.
    modport master (
        output alu_valid_i, alu_rd_i, alu_data_i,
        output mem_valid_i, mem_rd_i, mem_data_i,
        output wr_stall_i,
        input  alu_ready_o, mem_ready_o,
        input  reg_write_o, wr_register_o, wr_data_o,
        input  pending_o, count_o
    );

    // Consumer side: the write-back unit itself.
    modport slave (
        input  alu_valid_i, alu_rd_i, alu_data_i,
        input  mem_valid_i, mem_rd_i, mem_data_i,
        input  wr_stall_i,
        output alu_ready_o, mem_ready_o,
        output reg_write_o, wr_register_o, wr_data_o,
        output pending_o, count_o
    );

endinterface : regfile_writeback_unit_if

// File: rtl/regfile_writeback_unit_wb_fifo.sv
// Dual-push, single-pop synchronous FIFO of {rd, data} entries. Push slot 0
// is always the older entry; push slot 1 lands right behind it. The per-entry
// valid vector and destination indices are exposed so the owner can build a
// pending-write mask without a second copy of the queue.
module regfile_writeback_unit_wb_fifo
    import regfile_writeback_unit_pkg::*;
#(
    parameter int DATA_WIDTH = WB_DATA_WIDTH,
    parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
    parameter int FIFO_DEPTH = WB_FIFO_DEPTH
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  push0_en_i,
    input  logic [ADDR_WIDTH-1:0]                 push0_rd_i,
    input  logic [DATA_WIDTH-1:0]                 push0_data_i,
    input  logic                                  push1_en_i,
    input  logic [ADDR_WIDTH-1:0]                 push1_rd_i,
    input  logic [DATA_WIDTH-1:0]                 push1_data_i,
    input  logic                                  pop_en_i,
    output logic [ADDR_WIDTH-1:0]                 head_rd_o,
    output logic [DATA_WIDTH-1:0]                 head_data_o,
    output logic [$clog2(FIFO_DEPTH):0]           count_o,
    output logic [FIFO_DEPTH-1:0]                 entry_valid_o,
    output logic [FIFO_DEPTH-1:0][ADDR_WIDTH-1:0] entry_rd_o
);
    localparam int PTR_WIDTH = $clog2(FIFO_DEPTH);
    localparam int CNT_WIDTH = PTR_WIDTH + 1;
    localparam logic [PTR_WIDTH-1:0] PTR_ONE = PTR_WIDTH'(1);

    logic [FIFO_DEPTH-1:0][ADDR_WIDTH-1:0] slot_rd_q,    slot_rd_d;
    logic [FIFO_DEPTH-1:0][DATA_WIDTH-1:0] slot_data_q,  slot_data_d;
    logic [FIFO_DEPTH-1:0]                 slot_valid_q, slot_valid_d;
    logic [PTR_WIDTH-1:0]                  wr_ptr_q,     wr_ptr_d;
    logic [PTR_WIDTH-1:0]                  rd_ptr_q,     rd_ptr_d;
    logic [CNT_WIDTH-1:0]                  count_q,      count_d;
    logic [PTR_WIDTH-1:0]                  push1_slot_s;
    logic [1:0]                            push_cnt_s;

    // Next-state of storage, pointers and occupancy for up to two pushes and one pop.
    always_comb begin
        slot_rd_d    = slot_rd_q;
        slot_data_d  = slot_data_q;
        slot_valid_d = slot_valid_q;
        push_cnt_s   = {1'b0, push0_en_i} + {1'b0, push1_en_i};

        if (push0_en_i) begin
            push1_slot_s = wr_ptr_q + PTR_ONE;
        end else begin
            push1_slot_s = wr_ptr_q;
        end

        // Pushed slots are always free slots, so they never coincide with the popped head.
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (push0_en_i && (wr_ptr_q == PTR_WIDTH'(i))) begin
                slot_rd_d[i]    = push0_rd_i;
                slot_data_d[i]  = push0_data_i;
                slot_valid_d[i] = 1'b1;
            end else if (push1_en_i && (push1_slot_s == PTR_WIDTH'(i))) begin
                slot_rd_d[i]    = push1_rd_i;
                slot_data_d[i]  = push1_data_i;
                slot_valid_d[i] = 1'b1;
            end else if (pop_en_i && (rd_ptr_q == PTR_WIDTH'(i))) begin
                slot_valid_d[i] = 1'b0;
            end else begin
                slot_valid_d[i] = slot_valid_q[i];
            end
        end

        // Pointers wrap naturally because the depth is a power of two.
        wr_ptr_d = wr_ptr_q + PTR_WIDTH'(push_cnt_s);
        rd_ptr_d = rd_ptr_q + PTR_WIDTH'(pop_en_i);
        count_d  = count_q + CNT_WIDTH'(push_cnt_s) - CNT_WIDTH'(pop_en_i);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_rd_q    <= '0;
            slot_data_q  <= '0;
            slot_valid_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            slot_rd_q    <= slot_rd_d;
            slot_data_q  <= slot_data_d;
            slot_valid_q <= slot_valid_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    assign head_rd_o     = slot_rd_q[rd_ptr_q];
    assign head_data_o   = slot_data_q[rd_ptr_q];
    assign count_o       = count_q;
    assign entry_valid_o = slot_valid_q;
    assign entry_rd_o    = slot_rd_q;

endmodule : regfile_writeback_unit_wb_fifo

// File: rtl/regfile_writeback_unit.sv
// Write-side front end of the register file: accepts ALU and load results,
// drops writes to x0, queues the rest (load before ALU when both arrive in
// one cycle) and drains them one per cycle into the single write port.
// Also publishes which registers still have a queued write.
module regfile_writeback_unit
    import regfile_writeback_unit_pkg::*;
#(
    parameter int DATA_WIDTH = WB_DATA_WIDTH,
    parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
    parameter int FIFO_DEPTH = WB_FIFO_DEPTH
) (
    input  logic                     clock_i,
    input  logic                     reset_i,
    regfile_writeback_unit_if.slave  wb
);
    localparam int CNT_WIDTH = $clog2(FIFO_DEPTH) + 1;
    localparam int NUM_REGS  = 1 << ADDR_WIDTH;

    localparam logic [CNT_WIDTH-1:0]  CNT_ZERO    = CNT_WIDTH'(0);
    localparam logic [CNT_WIDTH-1:0]  CNT_FULL    = CNT_WIDTH'(FIFO_DEPTH);
    localparam logic [CNT_WIDTH-1:0]  CNT_FULL_M1 = CNT_WIDTH'(FIFO_DEPTH - 1);
    localparam logic [CNT_WIDTH-1:0]  CNT_FULL_M2 = CNT_WIDTH'(FIFO_DEPTH - 2);
    localparam logic [ADDR_WIDTH-1:0] X0_RD       = ADDR_WIDTH'(WB_X0_IDX);

    logic [CNT_WIDTH-1:0]                  count_s;
    logic [ADDR_WIDTH-1:0]                 head_rd_s;
    logic [DATA_WIDTH-1:0]                 head_data_s;
    logic [FIFO_DEPTH-1:0]                 entry_valid_s;
    logic [FIFO_DEPTH-1:0][ADDR_WIDTH-1:0] entry_rd_s;

    logic                  alu_ready_s;
    logic                  mem_ready_s;
    logic                  alu_push_s;
    logic                  mem_push_s;
    logic                  push0_en_s;
    logic [ADDR_WIDTH-1:0] push0_rd_s;
    logic [DATA_WIDTH-1:0] push0_data_s;
    logic                  push1_en_s;
    logic [ADDR_WIDTH-1:0] push1_rd_s;
    logic [DATA_WIDTH-1:0] push1_data_s;
    logic                  pop_s;
    logic                  reg_write_s;
    logic [ADDR_WIDTH-1:0] wr_register_s;
    logic [DATA_WIDTH-1:0] wr_data_s;
    logic [NUM_REGS-1:0]   pending_s;

    // Ready from registered occupancy only; the load gets the last free slot.
    always_comb begin
        alu_ready_s = 1'b0;
        mem_ready_s = 1'b0;
        if (reset_i) begin
            mem_ready_s = (count_s < CNT_FULL);
            alu_ready_s = (count_s <= CNT_FULL_M2) ||
                          ((count_s == CNT_FULL_M1) && !wb.mem_valid_i);
        end else begin
            alu_ready_s = 1'b0;
            mem_ready_s = 1'b0;
        end
        // A completed handshake to x0 consumes no slot.
        mem_push_s = wb.mem_valid_i && mem_ready_s && (wb.mem_rd_i != X0_RD);
        alu_push_s = wb.alu_valid_i && alu_ready_s && (wb.alu_rd_i != X0_RD);
    end

    // Push ordering: the load is the older instruction, so it goes in first.
    always_comb begin
        push0_en_s   = 1'b0;
        push0_rd_s   = wb.alu_rd_i;
        push0_data_s = wb.alu_data_i;
        push1_en_s   = 1'b0;
        push1_rd_s   = wb.alu_rd_i;
        push1_data_s = wb.alu_data_i;
        if (mem_push_s) begin
            push0_en_s   = 1'b1;
            push0_rd_s   = wb.mem_rd_i;
            push0_data_s = wb.mem_data_i;
            push1_en_s   = alu_push_s;
        end else begin
            push0_en_s   = alu_push_s;
            push1_en_s   = 1'b0;
        end
    end

    // Write port: present the head whenever one exists; write unless stalled or in reset.
    always_comb begin
        reg_write_s   = 1'b0;
        wr_register_s = X0_RD;
        wr_data_s     = {DATA_WIDTH{1'b0}};
        if (count_s != CNT_ZERO) begin
            wr_register_s = head_rd_s;
            wr_data_s     = head_data_s;
            reg_write_s   = !wb.wr_stall_i && reset_i;
        end else begin
            reg_write_s   = 1'b0;
        end
        pop_s = reg_write_s;
    end

    // Pending mask: one-hot of every queued destination, OR-ed together; x0 never pends.
    always_comb begin
        pending_s = {NUM_REGS{1'b0}};
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (entry_valid_s[i]) begin
                pending_s[entry_rd_s[i]] = 1'b1;
            end else begin
                pending_s = pending_s;
            end
        end
        pending_s[WB_X0_IDX] = 1'b0;
    end

    regfile_writeback_unit_wb_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_wb_fifo (
        .clk           (clock_i),
        .rst_n         (reset_i),
        .push0_en_i    (push0_en_s),
        .push0_rd_i    (push0_rd_s),
        .push0_data_i  (push0_data_s),
        .push1_en_i    (push1_en_s),
        .push1_rd_i    (push1_rd_s),
        .push1_data_i  (push1_data_s),
        .pop_en_i      (pop_s),
        .head_rd_o     (head_rd_s),
        .head_data_o   (head_data_s),
        .count_o       (count_s),
        .entry_valid_o (entry_valid_s),
        .entry_rd_o    (entry_rd_s)
    );

    assign wb.alu_ready_o   = alu_ready_s;
    assign wb.mem_ready_o   = mem_ready_s;
    assign wb.reg_write_o   = reg_write_s;
    assign wb.wr_register_o = wr_register_s;
    assign wb.wr_data_o     = wr_data_s;
    assign wb.pending_o     = pending_s;
    assign wb.count_o       = count_s;

endmodule : regfile_writeback_unit
